// File: rtl/game_map_pkg.sv
// Shared tile-map definitions for the player controller and the sprite/tile address generator.
// Row 0 is the top of the screen; within a row, bit 19 is column 0.
package game_map_pkg;

    localparam int unsigned TILE_SIZE   = 32;
    localparam int unsigned MAP_W       = 20;
    localparam int unsigned MAP_H       = 15;
    localparam int unsigned IMG_W       = 32;
    localparam int unsigned IMG_H       = 32;
    localparam int unsigned WALK_FRAMES = 6;
    localparam int unsigned IDLE_FRAMES = 4;

    localparam logic [9:0] START_X = 10'd32;
    localparam logic [9:0] START_Y = 10'd416;

    localparam logic [MAP_W-1:0] TILE_MAP [MAP_H] = '{
        20'b1111_1111_1111_1111_1111,  // 0
        20'b1000_0000_0000_0000_0001,  // 1
        20'b1000_0000_0000_0000_0001,  // 2
        20'b1000_0000_0000_0000_0001,  // 3
        20'b1000_0000_0000_0000_0001,  // 4
        20'b1000_0000_0000_0000_0001,  // 5
        20'b1000_0000_0000_0000_0001,  // 6
        20'b1000_0000_0000_0000_0001,  // 7
        20'b1000_0000_0000_0000_0001,  // 8
        20'b1000_0000_0000_0000_0001,  // 9
        20'b1000_0000_0000_0000_0001,  // 10
        20'b1111_0000_0000_0000_0001,  // 11: low ceiling over columns 1..3
        20'b1000_0000_0000_0000_0001,  // 12
        20'b1000_0000_0000_0001_0001,  // 13: wall block at column 15
        20'b1111_1111_1111_1111_1111   // 14: floor
    };

    typedef enum logic [2:0] {
        StIdle,
        StHProbe0,
        StHProbe1,
        StHCommit,
        StVProbe0,
        StVProbe1,
        StVCommit,
        StAnim
    } char_state_t;

    // Caller guarantees gx < MAP_W and gy < MAP_H.
    function automatic logic map_solid(input logic [4:0] gx, input logic [3:0] gy);
        logic [4:0] bit_idx;
        bit_idx = 5'(MAP_W - 1) - gx;
        return TILE_MAP[gy][bit_idx];
    endfunction

endpackage

// File: rtl/tile_probe.sv
// Combinational tile lookup: pixel (px, py) -> solid. Anything off the map, including
// negative coordinates, reads as solid.
module tile_probe
    import game_map_pkg::*;
(
    input  logic signed [10:0] px,
    input  logic signed [10:0] py,
    output logic               solid
);

    logic [4:0] gx;
    logic [4:0] gy;
    logic       unused_low;

    assign gx = px[9:5];
    assign gy = py[9:5];
    assign unused_low = ^{px[4:0], py[4:0]};

    always_comb begin
        if (px[10] || py[10] || gx >= 5'(MAP_W) || gy >= 5'(MAP_H)) begin
            solid = 1'b1;
        end else begin
            solid = map_solid(gx, gy[3:0]);
        end
    end

endmodule

// File: rtl/char_motion_ctrl.sv
// Per-frame player controller: on each vsync rising edge moves, jumps and animates the sprite,
// probing one map cell per cycle. Define CHAR_JUMP_EN to build in jump, gravity and vertical steps.
module char_motion_ctrl
    import game_map_pkg::*;
#(
    parameter int H_SPEED  = 2,
    parameter int JUMP_V   = 10,
    parameter int GRAVITY  = 1,
    parameter int V_MAX    = 8,
    parameter int ANIM_DIV = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] img_x,
    output logic [9:0] img_y,
    output logic [2:0] frame_idx,
    output logic       is_moving,
    output logic       face_left
);

    char_state_t state;

    logic               vsync_d;
    logic               tick;
    logic               btn_l_q;
    logic               btn_r_q;
    logic               move_l;
    logic               move_r;
    logic               moving;
    logic               hit_q;
    logic               solid;
    logic               mv_chg;
    logic [7:0]         anim_div;
    logic [2:0]         frame_lim;
    logic signed [10:0] x_s;
    logic signed [10:0] y_s;
    logic signed [10:0] cx;
    logic signed [10:0] lead_x;
    logic signed [10:0] probe_x;
    logic signed [10:0] probe_y;
    logic [9:0]         x_base;
    logic [9:0]         x_hit;

    assign tick   = vsync & ~vsync_d;
    assign move_l = btn_l_q & ~btn_r_q;
    assign move_r = btn_r_q & ~btn_l_q;
    assign moving = move_l | move_r;

    assign x_s    = signed'({1'b0, img_x});
    assign y_s    = signed'({1'b0, img_y});
    assign cx     = move_r ? x_s + 11'(H_SPEED) : x_s - 11'(H_SPEED);
    assign lead_x = move_r ? cx + 11'sd31 : cx;
    // Snap against the hit tile; a negative lead edge wraps to 0 via modulo-1024 arithmetic.
    assign x_base = {lead_x[9:5], 5'd0};
    assign x_hit  = move_r ? x_base - 10'd32 : x_base + 10'd32;

    assign frame_lim = is_moving ? 3'(WALK_FRAMES - 1) : 3'(IDLE_FRAMES - 1);

`ifdef CHAR_JUMP_EN
    logic               btn_j_q;
    logic               grounded;
    logic               grounded_nxt;
    logic signed [5:0]  vel;
    logic signed [5:0]  vel_hit;
    logic signed [5:0]  vel_nxt;
    logic signed [6:0]  vel_sum;
    logic signed [10:0] cy;
    logic signed [10:0] vprobe_y;
    logic [9:0]         y_base;
    logic [9:0]         y_nxt;

    always_comb begin
        cy = y_s + 11'(vel);
        if (vel > 0) begin
            vprobe_y = cy + 11'sd31;
        end else if (vel < 0) begin
            vprobe_y = cy;
        end else begin
            vprobe_y = y_s + 11'sd32;
        end
        y_base       = {vprobe_y[9:5], 5'd0};
        y_nxt        = img_y;
        vel_hit      = '0;
        grounded_nxt = 1'b0;
        if (vel == 0) begin
            grounded_nxt = hit_q;
        end else if (!hit_q) begin
            y_nxt   = cy[9:0];
            vel_hit = vel;
        end else if (vel > 0) begin
            y_nxt        = y_base - 10'd32;
            grounded_nxt = 1'b1;
        end else begin
            y_nxt = y_base + 10'd32;
        end
        vel_sum = 7'(vel_hit) + 7'(GRAVITY);
        vel_nxt = vel_hit;
        if (!grounded_nxt) begin
            vel_nxt = (vel_sum > 7'(V_MAX)) ? 6'(V_MAX) : vel_sum[5:0];
        end
    end
`else
    logic unused_jump;

    assign unused_jump = btn_jump;
    assign img_y       = START_Y;
`endif

    always_comb begin
        probe_x = lead_x;
        probe_y = y_s;
        case (state)
            StHProbe1: probe_y = y_s + 11'sd31;
`ifdef CHAR_JUMP_EN
            StVProbe0: probe_y = vprobe_y;
            StVProbe1: begin
                probe_x = x_s + 11'sd31;
                probe_y = vprobe_y;
            end
`endif
            default: ;
        endcase
        if (state == StVProbe0) begin
            probe_x = x_s;
        end
    end

    tile_probe u_tile_probe (
        .px    (probe_x),
        .py    (probe_y),
        .solid (solid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            vsync_d   <= 1'b0;
            btn_l_q   <= 1'b0;
            btn_r_q   <= 1'b0;
            hit_q     <= 1'b0;
            mv_chg    <= 1'b0;
            anim_div  <= '0;
            img_x     <= START_X;
            frame_idx <= '0;
            is_moving <= 1'b0;
            face_left <= 1'b0;
`ifdef CHAR_JUMP_EN
            img_y     <= START_Y;
            btn_j_q   <= 1'b0;
            vel       <= '0;
            grounded  <= 1'b0;
`endif
        end else begin
            vsync_d <= vsync;
            unique case (state)
                StIdle: begin
                    if (tick) begin
                        btn_l_q <= btn_left;
                        btn_r_q <= btn_right;
`ifdef CHAR_JUMP_EN
                        btn_j_q <= btn_jump;
`endif
                        state   <= StHProbe0;
                    end
                end
                StHProbe0: begin
                    hit_q <= solid;
`ifdef CHAR_JUMP_EN
                    if (grounded && btn_j_q) begin
                        vel <= 6'(-JUMP_V);
                    end
`endif
                    state <= StHProbe1;
                end
                StHProbe1: begin
                    hit_q <= hit_q | solid;
                    state <= StHCommit;
                end
                StHCommit: begin
                    // With no direction the probe results are simply ignored.
                    if (moving) begin
                        img_x     <= hit_q ? x_hit : cx[9:0];
                        face_left <= move_l;
                    end
                    is_moving <= moving;
                    mv_chg    <= is_moving ^ moving;
`ifdef CHAR_JUMP_EN
                    state     <= StVProbe0;
`else
                    state     <= StAnim;
`endif
                end
`ifdef CHAR_JUMP_EN
                StVProbe0: begin
                    hit_q <= solid;
                    state <= StVProbe1;
                end
                StVProbe1: begin
                    hit_q <= hit_q | solid;
                    state <= StVCommit;
                end
                StVCommit: begin
                    img_y    <= y_nxt;
                    vel      <= vel_nxt;
                    grounded <= grounded_nxt;
                    state    <= StAnim;
                end
`endif
                StAnim: begin
                    if (mv_chg) begin
                        frame_idx <= '0;
                        anim_div  <= '0;
                    end else if (anim_div == 8'(ANIM_DIV - 1)) begin
                        anim_div  <= '0;
                        frame_idx <= (frame_idx >= frame_lim) ? 3'd0 : frame_idx + 3'd1;
                    end else begin
                        anim_div <= anim_div + 8'd1;
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Scoreboard bench for char_motion_ctrl: stimulus queues expected outputs per frame tick,
// a monitor pops and compares once the update has settled (or immediately on reset).
module tb_char_motion_ctrl;

    localparam int ANIM_DIV = 6;
    localparam int LAT      = 10;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] f;
        logic       mv;
        logic       fl;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       vsync;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic [9:0] img_x;
    logic [9:0] img_y;
    logic [2:0] frame_idx;
    logic       is_moving;
    logic       face_left;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_pass  = 0;
    int    n_total = 0;

    // Animation / facing model driven by the stimulus
    int   m_frame;
    int   m_div;
    logic m_mv;
    logic m_fl;

    char_motion_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .vsync     (vsync),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_jump  (btn_jump),
        .img_x     (img_x),
        .img_y     (img_y),
        .frame_idx (frame_idx),
        .is_moving (is_moving),
        .face_left (face_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [9:0] act,
                       input logic [9:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s %s: got %0d, expected %0d", nm, fld, act, want);
    endtask

    task automatic check_front();
        exp_t  e;
        string nm;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard_underflow: got output event with 0 queued, expected 1");
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            cmp(nm, "img_x", img_x, e.x);
            cmp(nm, "img_y", img_y, e.y);
            cmp(nm, "frame_idx", {7'd0, frame_idx}, {7'd0, e.f});
            cmp(nm, "is_moving", {9'd0, is_moving}, {9'd0, e.mv});
            cmp(nm, "face_left", {9'd0, face_left}, {9'd0, e.fl});
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge vsync or posedge rst);
            if (!rst) begin
                for (int i = 0; i < LAT; i++) begin
                    @(posedge clk or posedge rst);
                    if (rst) break;
                end
            end
            #1;
            check_front();
            if (rst) wait (!rst);
        end
    end

    task automatic push_exp(input string nm, input int ex, input int ey, input int fr,
                            input logic mv, input logic fl);
        exp_t e;
        e.x  = 10'(ex);
        e.y  = 10'(ey);
        e.f  = 3'(fr);
        e.mv = mv;
        e.fl = fl;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic push_reset(input string nm);
        push_exp(nm, 32, 416, 0, 1'b0, 1'b0);
        m_frame = 0;
        m_div   = 0;
        m_mv    = 1'b0;
        m_fl    = 1'b0;
    endtask

    task automatic do_tick(input logic l, input logic r, input logic j);
        @(negedge clk);
        btn_left  = l;
        btn_right = r;
        btn_jump  = j;
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic step(input string nm, input logic l, input logic r, input logic j,
                        input int ex, input int ey);
        logic mv;
        mv = l ^ r;
        if (l && !r) m_fl = 1'b1;
        else if (r && !l) m_fl = 1'b0;
        if (mv != m_mv) begin
            m_frame = 0;
            m_div   = 0;
        end else if (m_div == ANIM_DIV - 1) begin
            m_div   = 0;
            m_frame = (m_frame + 1 == (mv ? 6 : 4)) ? 0 : m_frame + 1;
        end else begin
            m_div++;
        end
        m_mv = mv;
        push_exp(nm, ex, ey, m_frame, mv, m_fl);
        do_tick(l, r, j);
    endtask

    task automatic pulse_reset(input string nm);
        @(negedge clk);
        push_reset(nm);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin : stimulus
        int ex;
`ifdef CHAR_JUMP_EN
        int ys[12] = '{397, 389, 384, 385, 387, 390, 394, 399, 405, 412, 416, 416};
`endif
        rst       = 1'b0;
        vsync     = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_jump  = 1'b0;
        push_reset("reset");
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        step("settle", 1'b0, 1'b0, 1'b0, 32, 416);

        for (int k = 1; k <= 10; k++) step("walk_right", 1'b0, 1'b1, 1'b0, 32 + 2 * k, 416);

        ex = 52;
        for (int k = 0; k < 300; k++) begin
            ex = (ex + 2 > 448) ? 448 : ex + 2;
            step("wall_stop", 1'b0, 1'b1, 1'b0, ex, 416);
        end

        for (int k = 1; k <= 3; k++) step("walk_left", 1'b1, 1'b0, 1'b0, 448 - 2 * k, 416);
        for (int k = 0; k < 5; k++) step("both_btns", 1'b1, 1'b1, 1'b0, 442, 416);
        for (int k = 0; k < 30; k++) step("idle_anim", 1'b0, 1'b0, 1'b0, 442, 416);

        pulse_reset("reset2");
        step("settle2", 1'b0, 1'b0, 1'b0, 32, 416);

`ifdef CHAR_JUMP_EN
        step("jump", 1'b0, 1'b0, 1'b1, 32, 406);
        foreach (ys[i]) step("jump_arc", 1'b0, 1'b0, 1'b0, 32, ys[i]);
        step("rejump", 1'b0, 1'b0, 1'b1, 32, 406);
        step("rejump_rise", 1'b0, 1'b0, 1'b0, 32, 397);
`else
        for (int k = 0; k < 3; k++) step("jump_ignored", 1'b0, 1'b0, 1'b1, 32, 416);
`endif

        // Tick whose update is cut short by an asynchronous reset
        @(negedge clk);
        btn_left  = 1'b0;
        btn_right = 1'b1;
        btn_jump  = 1'b1;
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        push_reset("async_rst");
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        step("post_rst", 1'b0, 1'b1, 1'b1, 34, 416);
`ifdef CHAR_JUMP_EN
        step("post_rst_jump", 1'b0, 1'b0, 1'b1, 34, 406);
`else
        step("post_rst_still", 1'b0, 1'b0, 1'b1, 34, 416);
`endif

        repeat (20) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
